// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM control path: FSM states, ALU controls,
// datapath select codes, condition field values and instruction classes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mc_cond_logic.sv
// Conditional execution: architectural NZCV flags, per-instruction condition latch
// and gating of the architectural write enables.
module mc_cond_logic
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       latch_cond_i,
    input  logic       next_pc_i,
    input  logic       branch_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       ir_write_i,
    input  logic       no_write_i,
    input  logic [3:0] rd_i,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       ir_write_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic       pcs_s;

    function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~(c & ~z);
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = ~(~z & (n == v));
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    // Flag/condition next-state; flag_w_i is only nonzero during the execute cycle
    always_comb begin
        flags_d      = flags_q;
        cond_d       = latch_cond_i ? cond_ex(cond_i, flags_q) : cond_q;
        flags_d[3:2] = (flag_w_i[1] & cond_q) ? alu_flags_i[3:2] : flags_q[3:2];
        flags_d[1:0] = (flag_w_i[0] & cond_q) ? alu_flags_i[1:0] : flags_q[1:0];
    end

    // Flag and condition registers; reset discards any in-flight update
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    assign pcs_s       = branch_i | (reg_w_i & (rd_i == 4'd15));
    assign pc_write_o  = ~reset_i & (next_pc_i | (pcs_s & cond_q));
    assign reg_write_o = ~reset_i & reg_w_i & cond_q & ~no_write_i;
    assign mem_write_o = ~reset_i & mem_w_i & cond_q;
    assign ir_write_o  = ~reset_i & ir_write_i;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle ARM control path: Moore main FSM and ALU decode, with conditional
// execution and write-enable gating delegated to mc_cond_logic.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        Reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUCtrl,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  state_o
);

    state_e    state_q, state_d;
    alu_ctrl_e alu_ctrl_s;
    logic [3:0] cond_s, rd_s;
    logic [1:0] op_s, flag_w_s;
    logic [5:0] funct_s;
    logic ir_write_s, next_pc_s, reg_w_s, mem_w_s, branch_s, alu_op_s, no_write_s;

    assign cond_s  = Instr[19:16];
    assign op_s    = Instr[15:14];
    assign funct_s = Instr[13:8];
    assign rd_s    = Instr[3:0];

    // Main FSM state register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore control outputs
    always_comb begin
        state_d    = S_FETCH;
        ir_write_s = 1'b0;
        next_pc_s  = 1'b0;
        reg_w_s    = 1'b0;
        mem_w_s    = 1'b0;
        branch_s   = 1'b0;
        alu_op_s   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                next_pc_s  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op_s)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct_s[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w_s   = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w_s = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_op_s = 1'b1;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB  = SRCB_IMM;
                alu_op_s = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w_s = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch_s  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decode; CMP suppresses write-back in ALUWB, where ALUOp is already 0
    always_comb begin
        alu_ctrl_s = ALU_ADD;
        flag_w_s   = 2'b00;
        no_write_s = (op_s == OP_DP) && (funct_s[4:1] == CMD_CMP);
        if (alu_op_s) begin
            case (funct_s[4:1])
                CMD_ADD: alu_ctrl_s = ALU_ADD;
                CMD_SUB: alu_ctrl_s = ALU_SUB;
                CMD_AND: alu_ctrl_s = ALU_AND;
                CMD_ORR: alu_ctrl_s = ALU_ORR;
                CMD_CMP: alu_ctrl_s = ALU_SUB;
                default: alu_ctrl_s = ALU_ADD;
            endcase
            flag_w_s[1] = funct_s[0];
            flag_w_s[0] = funct_s[0] & ((alu_ctrl_s == ALU_ADD) || (alu_ctrl_s == ALU_SUB));
        end else begin
            flag_w_s = 2'b00;
        end
    end

    mc_cond_logic u_cond (
        .clk_i        (clk),
        .reset_i      (Reset),
        .cond_i       (cond_s),
        .alu_flags_i  (ALUFlags),
        .flag_w_i     (flag_w_s),
        .latch_cond_i (state_q == S_DECODE),
        .next_pc_i    (next_pc_s),
        .branch_i     (branch_s),
        .reg_w_i      (reg_w_s),
        .mem_w_i      (mem_w_s),
        .ir_write_i   (ir_write_s),
        .no_write_i   (no_write_s),
        .rd_i         (rd_s),
        .pc_write_o   (PCWrite),
        .reg_write_o  (RegWrite),
        .mem_write_o  (MemWrite),
        .ir_write_o   (IRWrite)
    );

    assign ALUCtrl = alu_ctrl_s;
    assign RegSrc  = {op_s == OP_MEM, op_s == OP_BR};
    assign ImmSrc  = op_s;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed ARM sequences plus random instructions, each compared
// cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [19:0] Instr = 20'h00000;
    logic [3:0]  ALUFlags = 4'b0000;
    logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUCtrl, RegSrc, ImmSrc;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] m_flags = 4'b0000;

    multicycle_controller dut (
        .clk(clk), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUCtrl(ALUCtrl), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural condition: base test from Cond[3:1], inverted by Cond[0]
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    // {state, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUCtrl, RegSrc, ImmSrc}
    function automatic logic [19:0] mk(input logic [3:0] st, input bit pcw, input bit memw,
                                       input bit regw, input bit irw, input bit adr, input bit srca,
                                       input logic [1:0] srcb, input logic [1:0] res,
                                       input logic [1:0] alu, input logic [1:0] op);
        return {st, pcw, memw, regw, irw, adr, srca, srcb, res, alu, op == 2'b01, op == 2'b10, op};
    endfunction

    function automatic logic [19:0] observed();
        return {state_o, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUCtrl, RegSrc, ImmSrc};
    endfunction

    // Runs one instruction; abort_at>0 raises Reset during that cycle of the instruction
    task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] af,
                             input int abort_at);
        logic [19:0] tr[$];
        logic [1:0]  op, alu;
        logic [5:0]  funct;
        bit ex, wbpc, nw;
        int exec_pos = -1;
        op    = ins[15:14];
        funct = ins[13:8];
        ex    = m_cond(ins[19:16], m_flags);
        wbpc  = ex && (ins[3:0] == 4'd15);
        case (funct[4:1])
            4'b0010: begin alu = 2'b01; nw = 1'b0; end
            4'b0000: begin alu = 2'b10; nw = 1'b0; end
            4'b1100: begin alu = 2'b11; nw = 1'b0; end
            4'b1010: begin alu = 2'b01; nw = 1'b1; end
            default: begin alu = 2'b00; nw = 1'b0; end
        endcase
        tr.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, op));
        tr.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, op));
        case (op)
            2'b01: begin
                tr.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, op));
                if (funct[0]) begin
                    tr.push_back(mk(S_MEMREAD, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, op));
                    tr.push_back(mk(S_MEMWB, wbpc, 0, ex, 0, 0, 0, 2'b00, 2'b01, 2'b00, op));
                end else begin
                    tr.push_back(mk(S_MEMWRITE, 0, ex, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, op));
                end
            end
            2'b00: begin
                exec_pos = 2;
                tr.push_back(mk(funct[5] ? S_EXECI : S_EXECR, 0, 0, 0, 0, 0, 0,
                                funct[5] ? 2'b01 : 2'b00, 2'b00, alu, op));
                tr.push_back(mk(S_ALUWB, wbpc, 0, ex && !nw, 0, 0, 0, 2'b00, 2'b00, 2'b00, op));
            end
            2'b10: tr.push_back(mk(S_BRANCH, ex, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, op));
            default: ;
        endcase
        Instr    = ins;
        ALUFlags = af;
        for (int i = 0; i < tr.size(); i++) begin
            if (abort_at > 0 && i == abort_at) Reset = 1'b1;
            @(negedge clk);
            if (Reset)
                check_eq($sformatf("%s_rst_c%0d", name, i), observed(), tr[i] & ~20'h0F000);
            else
                check_eq($sformatf("%s_c%0d", name, i), observed(), tr[i]);
            @(posedge clk);
            #1;
            if (Reset) begin
                Reset   = 1'b0;
                m_flags = 4'b0000;
                break;
            end
            if (i == exec_pos && ex && funct[0]) begin
                m_flags[3:2] = af[3:2];
                if (alu == 2'b00 || alu == 2'b01) m_flags[1:0] = af[1:0];
            end
        end
        check_eq({name, "_flags"}, dut.u_cond.flags_q, m_flags);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] ins;
        int abort;
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", state_o, S_FETCH);
        check_eq("reset_enables", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        check_eq("reset_flags", dut.u_cond.flags_q, 4'b0000);
        @(posedge clk);
        #1;
        Reset = 1'b0;

        run_instr("ldr",  20'hE5901, 4'b0000, 0);
        run_instr("str",  20'hE5801, 4'b0000, 0);
        run_instr("subs", 20'hE0532, 4'b0100, 0);
        check_eq("subs_flags_z", dut.u_cond.flags_q, 4'b0100);
        run_instr("beq",  20'h0A000, 4'b0000, 0);
        run_instr("bne",  20'h1A000, 4'b0000, 0);
        run_instr("cmp",  20'hE1500, 4'b1000, 0);
        check_eq("cmp_flags_n", dut.u_cond.flags_q, 4'b1000);
        run_instr("str_abort", 20'hE5801, 4'b0110, 2);
        check_eq("abort_flags", dut.u_cond.flags_q, 4'b0000);
        run_instr("undef", 20'hEC000, 4'b0000, 0);

        for (int k = 0; k < 400; k++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_instr($sformatf("rnd%0d", k), ins, 4'($urandom), abort);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
